// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the DDS wave segment sequencer.
// Field selects, FSM state encoding and default widths.
package wave_seq_pkg;

  localparam int NUM_CH_DEF = 64;
  localparam int AMP_W_DEF  = 16;
  localparam int TIME_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  localparam logic [1:0] FLD_AMP = 2'd0;
  localparam logic [1:0] FLD_OFS = 2'd1;
  localparam logic [1:0] FLD_PHW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWAP,
    ST_RUN,
    ST_HOLD
  } state_t;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_seq_if.sv
// Host/output bundle of the segment sequencer.
// Optional underrun_count exists only with WAVE_SEQ_UNDERRUN_CNT_EN.
interface wave_seq_if
  import wave_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int AMP_W  = AMP_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int CH_W = ch_w(NUM_CH);

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [1:0]        wr_field;
  logic [AMP_W-1:0]  wr_data;
  logic              commit;
  logic [TIME_W-1:0] commit_time;
  logic              start;
  logic              abort;
  logic              loop_en;

  logic [NUM_CH*AMP_W-1:0] active_amps;
  logic [NUM_CH*AMP_W-1:0] active_offsets;
  logic [NUM_CH*AMP_W-1:0] active_phwords;
  logic              dds_reset;
  logic              sample_valid;
  logic              seg_done;
  logic              pending;
  logic              busy;
  logic              underrun;
  logic [CNT_W-1:0]  seg_count;
`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
  logic [CNT_W-1:0]  underrun_count;
`endif

  modport master (
`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
    input  underrun_count,
`endif
    output wr_en, wr_ch, wr_field, wr_data,
    output commit, commit_time,
    output start, abort, loop_en,
    input  active_amps, active_offsets,
    input  active_phwords, dds_reset,
    input  sample_valid, seg_done, pending,
    input  busy, underrun, seg_count
  );

  modport slave (
`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
    output underrun_count,
`endif
    input  wr_en, wr_ch, wr_field, wr_data,
    input  commit, commit_time,
    input  start, abort, loop_en,
    output active_amps, active_offsets,
    output active_phwords, dds_reset,
    output sample_valid, seg_done, pending,
    output busy, underrun, seg_count
  );

endinterface

// File: rtl/wave_segment_sequencer_bank.sv
// Staging + active storage for one per-channel field.
// Swap copies the pre-write staging image into the active bank.
module wave_param_bank #(
  parameter int NUM_CH = 64,
  parameter int AMP_W  = 16,
  parameter int CH_W   = 6
) (
  input  logic                    clk1,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [AMP_W-1:0]        wr_data,
  input  logic                    swap,
  output logic [NUM_CH*AMP_W-1:0] active
);

  logic [NUM_CH*AMP_W-1:0] stg;
  logic                    hit;

  assign hit = wr_en && (int'(wr_ch) < NUM_CH);

  always_ff @(posedge clk1) begin
    if (reset) begin
      stg    <= '0;
      active <= '0;
    end else begin
      if (hit)
        stg[int'(wr_ch)*AMP_W +: AMP_W] <= wr_data;
      if (swap)
        active <= stg;
    end
  end

endmodule

// File: rtl/wave_segment_sequencer.sv
// Segment scheduler: banks swap at boundaries, timer gates samples.
// Define WAVE_SEQ_UNDERRUN_CNT_EN to add a saturating underrun_count.
module wave_segment_sequencer
  import wave_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int AMP_W  = AMP_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic     clk1,
  input  logic     reset,
  wave_seq_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);

  state_t            state;
  logic [TIME_W-1:0] timer;
  logic [TIME_W-1:0] dur;
  logic [TIME_W-1:0] load;
  logic [CNT_W-1:0]  cnt;
  logic              pend;
  logic              svalid;
  logic              dres;
  logic              sdone;
  logic              urun;
  logic              swap;
  logic [2:0]        fld_en;

  assign load = (dur == '0) ? '0 : dur - TIME_W'(1);
  assign swap = (state == ST_SWAP) && !bus.abort;

  always_comb begin
    fld_en = '0;
    unique case (1'b1)
      (bus.wr_field == FLD_AMP): fld_en[0] = bus.wr_en;
      (bus.wr_field == FLD_OFS): fld_en[1] = bus.wr_en;
      (bus.wr_field == FLD_PHW): fld_en[2] = bus.wr_en;
      default:                   fld_en    = '0;
    endcase
  end

  wave_param_bank #(.NUM_CH(NUM_CH), .AMP_W(AMP_W), .CH_W(CH_W)) u_amp (
    .clk1(clk1), .reset(reset), .wr_en(fld_en[0]), .wr_ch(bus.wr_ch),
    .wr_data(bus.wr_data), .swap(swap), .active(bus.active_amps)
  );

  wave_param_bank #(.NUM_CH(NUM_CH), .AMP_W(AMP_W), .CH_W(CH_W)) u_ofs (
    .clk1(clk1), .reset(reset), .wr_en(fld_en[1]), .wr_ch(bus.wr_ch),
    .wr_data(bus.wr_data), .swap(swap), .active(bus.active_offsets)
  );

  wave_param_bank #(.NUM_CH(NUM_CH), .AMP_W(AMP_W), .CH_W(CH_W)) u_phw (
    .clk1(clk1), .reset(reset), .wr_en(fld_en[2]), .wr_ch(bus.wr_ch),
    .wr_data(bus.wr_data), .swap(swap), .active(bus.active_phwords)
  );

  // seg_done is registered, so it is raised on entry to the timer==0 cycle
  always_ff @(posedge clk1) begin
    if (reset) begin
      state  <= ST_IDLE;
      timer  <= '0;
      dur    <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      svalid <= 1'b0;
      dres   <= 1'b0;
      sdone  <= 1'b0;
      urun   <= 1'b0;
    end else if (bus.abort) begin
      state  <= ST_IDLE;
      pend   <= 1'b0;
      svalid <= 1'b0;
      dres   <= 1'b0;
      sdone  <= 1'b0;
      urun   <= 1'b0;
    end else begin
      dres  <= 1'b0;
      sdone <= 1'b0;
      if (bus.start)
        urun <= 1'b0;
      if (bus.commit) begin
        pend <= 1'b1;
        dur  <= bus.commit_time;
      end
      unique case (state)
        ST_IDLE: begin
          if (bus.start && pend) begin
            state <= ST_SWAP;
            cnt   <= '0;
          end
        end
        ST_SWAP: begin
          timer  <= load;
          pend   <= bus.commit;
          cnt    <= cnt + CNT_W'(1);
          svalid <= 1'b1;
          dres   <= 1'b1;
          sdone  <= (load == '0);
          state  <= ST_RUN;
        end
        ST_RUN: begin
          if (timer != '0) begin
            timer <= timer - TIME_W'(1);
            sdone <= (timer == TIME_W'(1));
          end else if (pend) begin
            svalid <= 1'b0;
            state  <= ST_SWAP;
          end else if (bus.loop_en) begin
            timer <= load;
            sdone <= (load == '0);
          end else begin
            urun   <= 1'b1;
            svalid <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (pend)
            state <= ST_SWAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
  logic [CNT_W-1:0] ucnt;
  logic             uevt;

  assign uevt = (state == ST_RUN) && (timer == '0) && !pend
             && !bus.loop_en && !bus.abort;

  always_ff @(posedge clk1) begin
    if (reset)
      ucnt <= '0;
    else if (uevt && (ucnt != '1))
      ucnt <= ucnt + CNT_W'(1);
  end

  assign bus.underrun_count = ucnt;
`endif

  assign bus.dds_reset    = dres;
  assign bus.sample_valid = svalid;
  assign bus.seg_done     = sdone;
  assign bus.pending      = pend;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.underrun     = urun;
  assign bus.seg_count    = cnt;

endmodule

// File: tb/tb_wave_segment_sequencer.sv
// Scoreboard bench: stimulus queues expected sample cycles,
// a negedge monitor pops and compares them.
module tb_wave_segment_sequencer;
  import wave_seq_pkg::*;

  localparam int NCH = 5;
  localparam int AW  = 16;
  localparam int TW  = 16;
  localparam int CW  = 8;

  logic clk1;
  logic reset;

  wave_seq_if #(.NUM_CH(NCH), .AMP_W(AW), .TIME_W(TW), .CNT_W(CW)) bus ();

  wave_segment_sequencer #(
    .NUM_CH(NCH), .AMP_W(AW), .TIME_W(TW), .CNT_W(CW)
  ) dut (
    .clk1(clk1),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        dr;
    logic        sd;
    logic [7:0]  cnt;
    logic [15:0] a0;
    logic [15:0] a3;
    int          gap;
    bit          cg;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   gap      = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_one(logic dr, logic sd, int cnt, int a0, int a3,
                          int g, bit cg);
    exp_t e;
    e.dr = dr; e.sd = sd; e.cnt = 8'(cnt);
    e.a0 = 16'(a0); e.a3 = 16'(a3);
    e.gap = g; e.cg = cg;
    q.push_back(e);
  endtask

  task automatic push_seg(int d, int cnt, int a0, int a3, logic dr,
                          int g, bit cg);
    int n;
    n = (d == 0) ? 1 : d;
    for (int i = 0; i < n; i++) begin
      if (i == 0) push_one(dr, (n == 1), cnt, a0, a3, g, cg);
      else        push_one(1'b0, (i == n - 1), cnt, a0, a3, 0, 1'b1);
    end
  endtask

  always @(negedge clk1) begin
    if (bus.sample_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dds_reset", 64'(bus.dds_reset), 64'(e.dr));
        chk("seg_done", 64'(bus.seg_done), 64'(e.sd));
        chk("seg_count", 64'(bus.seg_count), 64'(e.cnt));
        chk("amp_ch0", 64'(bus.active_amps[0 +: AW]), 64'(e.a0));
        chk("amp_ch3", 64'(bus.active_amps[3*AW +: AW]), 64'(e.a3));
        if (e.cg) chk("valid_gap", 64'(gap), 64'(e.gap));
      end
      gap = 0;
    end else begin
      if (reset === 1'b0)
        chk("pulse_outside_run", 64'({bus.dds_reset, bus.seg_done}), 64'(0));
      gap++;
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wr(int ch, logic [1:0] fld, int data);
    bus.wr_en = 1'b1; bus.wr_ch = 3'(ch);
    bus.wr_field = fld; bus.wr_data = 16'(data);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit(int t);
    bus.commit = 1'b1; bus.commit_time = 16'(t);
    step();
    bus.commit = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_ch = 0; bus.wr_field = 0; bus.wr_data = 0;
    bus.commit = 0; bus.commit_time = 0;
    bus.start = 0; bus.abort = 0; bus.loop_en = 0;

    // 1: one-shot segment of 5, then HOLD with underrun
    do_reset();
    chk("rst_valid", 64'(bus.sample_valid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_pending", 64'(bus.pending), 0);
    chk("rst_underrun", 64'(bus.underrun), 0);
    chk("rst_seg_count", 64'(bus.seg_count), 0);
    chk("rst_dds_reset", 64'(bus.dds_reset), 0);
    chk("rst_amps", 64'(bus.active_amps), 0);
`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
    chk("rst_underrun_count", 64'(bus.underrun_count), 0);
`endif
    wr(0, FLD_AMP, 'h1234);
    wr(0, FLD_OFS, 'h0055);
    wr(0, FLD_PHW, 'hABCD);
    wr(0, 2'd3, 'hFFFF);
    wr(7, FLD_AMP, 'hDEAD);
    do_commit(5);
    chk("t1_pending", 64'(bus.pending), 1);
    chk("t1_idle_busy", 64'(bus.busy), 0);
    chk("t1_amp_not_swapped", 64'(bus.active_amps[0 +: AW]), 0);
    push_seg(5, 1, 'h1234, 0, 1'b1, 0, 1'b0);
    do_start();
    step(7);
    chk("t1_underrun", 64'(bus.underrun), 1);
    chk("t1_hold_busy", 64'(bus.busy), 1);
    chk("t1_hold_valid", 64'(bus.sample_valid), 0);
    chk("t1_pending_clr", 64'(bus.pending), 0);
    chk("t1_seg_count", 64'(bus.seg_count), 1);
    chk("t1_ofs_ch0", 64'(bus.active_offsets[0 +: AW]), 'h55);
    chk("t1_phw_ch0", 64'(bus.active_phwords[0 +: AW]), 'hABCD);

    // 2: loop mode, three unbroken iterations of 3
    do_reset();
    wr(0, FLD_AMP, 'h0777);
    do_commit(3);
    bus.loop_en = 1'b1;
    push_seg(3, 1, 'h777, 0, 1'b1, 0, 1'b0);
    push_seg(3, 1, 'h777, 0, 1'b0, 0, 1'b1);
    push_seg(3, 1, 'h777, 0, 1'b0, 0, 1'b1);
    do_start();
    step(9);
    bus.loop_en = 1'b0;
    step();
    chk("t2_underrun", 64'(bus.underrun), 1);
    chk("t2_valid", 64'(bus.sample_valid), 0);
    chk("t2_seg_count", 64'(bus.seg_count), 1);

    // 3: B committed during A swaps in after one gap cycle
    do_reset();
    wr(0, FLD_AMP, 'h00A1);
    do_commit(3);
    push_seg(3, 1, 'hA1, 0, 1'b1, 0, 1'b0);
    do_start();
    wr(0, FLD_AMP, 'h00B2);
    push_seg(4, 2, 'hB2, 0, 1'b1, 1, 1'b1);
    do_commit(4);
    step(8);
    chk("t3_seg_count", 64'(bus.seg_count), 2);
    chk("t3_underrun", 64'(bus.underrun), 1);
    chk("t3_valid", 64'(bus.sample_valid), 0);

    // 4: zero duration, then recovery from HOLD, then abort
    do_reset();
    do_commit(0);
    push_seg(0, 1, 0, 0, 1'b1, 0, 1'b0);
    do_start();
    step(3);
    chk("t4_valid", 64'(bus.sample_valid), 0);
    chk("t4_underrun", 64'(bus.underrun), 1);
    push_seg(2, 2, 0, 0, 1'b1, 4, 1'b1);
    do_commit(2);
    step(4);
    chk("t4_seg_count", 64'(bus.seg_count), 2);
    chk("t4_hold_busy", 64'(bus.busy), 1);
    do_abort();
    chk("t4_abort_underrun", 64'(bus.underrun), 0);
    chk("t4_abort_busy", 64'(bus.busy), 0);

    // 5: abort mid-RUN drops pending; later start is ignored
    do_reset();
    do_commit(6);
    push_one(1'b1, 1'b0, 1, 0, 0, 0, 1'b0);
    do_start();
    do_commit(2);
    chk("t5_pending", 64'(bus.pending), 1);
    do_abort();
    chk("t5_busy", 64'(bus.busy), 0);
    chk("t5_pending_clr", 64'(bus.pending), 0);
    chk("t5_valid", 64'(bus.sample_valid), 0);
    do_start();
    step(3);
    chk("t5_restart_busy", 64'(bus.busy), 0);
    chk("t5_restart_valid", 64'(bus.sample_valid), 0);
    chk("t5_seg_count", 64'(bus.seg_count), 1);

    // 6: write on the SWAP cycle lands in staging only
    do_reset();
    wr(3, FLD_AMP, 'h0030);
    do_commit(2);
    push_seg(2, 1, 0, 'h30, 1'b1, 0, 1'b0);
    do_start();
    wr(3, FLD_AMP, 'h0031);
    push_seg(2, 2, 0, 'h31, 1'b1, 1, 1'b1);
    do_commit(2);
    step(4);
    chk("t6_underrun", 64'(bus.underrun), 1);
    chk("t6_seg_count", 64'(bus.seg_count), 2);
    push_seg(1, 3, 0, 'h31, 1'b1, 0, 1'b0);
    do_commit(1);
    step(4);
    push_seg(1, 4, 0, 'h31, 1'b1, 0, 1'b0);
    do_commit(1);
    step(4);
    chk("t6_seg_count_end", 64'(bus.seg_count), 4);
    chk("t6_valid_end", 64'(bus.sample_valid), 0);
`ifdef WAVE_SEQ_UNDERRUN_CNT_EN
    chk("t6_underrun_count", 64'(bus.underrun_count), 3);
`endif

    step(2);
    chk("queue_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
